// File: rtl/led_pwm_trail.sv
// led_pwm_trail: PWM-dimmed LED drive with optional fading trail (define LED_PWM_TRAIL_EN to enable decay)
module led_pwm_trail #(
  parameter int DECAY_DIV = 25000
) (
  input  logic       clk,
  input  logic       rs,
  input  logic [7:0] led_in,
  output logic [7:0] led_out
);
  logic [7:0][3:0] bright;
  logic [3:0] pwm_cnt;
  if (DECAY_DIV < 1 || DECAY_DIV > 65535) begin : g_bad_div
    $error("DECAY_DIV out of range 1..65535");
  end
`ifdef LED_PWM_TRAIL_EN
  localparam logic [15:0] LAST = 16'(DECAY_DIV - 1);
  logic [15:0] presc;
  logic decay_tick;
  assign decay_tick = presc == LAST;
  // free-running prescaler producing one decay step every DECAY_DIV cycles
  always_ff @(posedge clk) presc <= rs || decay_tick ? '0 : presc + 16'd1;
  // a lit input reloads full brightness; otherwise fade by one step per tick down to zero
  always_ff @(posedge clk)
    for (int i = 0; i < 8; i++)
      bright[i] <= rs ? 4'd0 : led_in[i] ? 4'd15 : decay_tick && bright[i] != 4'd0 ? bright[i] - 4'd1 : bright[i];
`else
  // no trail: brightness simply follows the input pattern
  always_ff @(posedge clk)
    for (int i = 0; i < 8; i++)
      bright[i] <= rs ? 4'd0 : led_in[i] ? 4'd15 : 4'd0;
`endif
  // 15-cycle PWM frame counter
  always_ff @(posedge clk) pwm_cnt <= rs || pwm_cnt == 4'd14 ? 4'd0 : pwm_cnt + 4'd1;
  // compare each brightness against the shared frame position
  always_ff @(posedge clk)
    for (int i = 0; i < 8; i++)
      led_out[i] <= !rs && bright[i] > pwm_cnt;
endmodule

// File: tb/tb_led_pwm_trail.sv
// tb_led_pwm_trail: scoreboard bench comparing led_pwm_trail against a behavioural brightness model
module tb_led_pwm_trail;
  logic clk = 1'b0;
  logic rs = 1'b1;
  logic [7:0] led_in = 8'h00;
  logic [7:0] led_out;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [7:0] lo;
    logic [7:0][3:0] br;
    logic [3:0] pc;
  } exp_t;
  exp_t q[$];
  int mb[8];
  int k = 0;

  always #5 clk = ~clk;

  led_pwm_trail #(.DECAY_DIV(4)) dut (.clk(clk), .rs(rs), .led_in(led_in), .led_out(led_out));

  // drive one edge's inputs and queue what the outputs must be after that edge
  task automatic step(input logic r, input logic [7:0] v);
    exp_t e;
    @(negedge clk);
    rs = r;
    led_in = v;
    for (int i = 0; i < 8; i++) begin
      e.lo[i] = !r && (mb[i] > k % 15);
      if (r) mb[i] = 0;
      else if (v[i]) mb[i] = 15;
`ifdef LED_PWM_TRAIL_EN
      else if (k % 4 == 3 && mb[i] > 0) mb[i] = mb[i] - 1;
`else
      else mb[i] = 0;
`endif
      e.br[i] = 4'(mb[i]);
    end
    e.pc = r ? 4'd0 : 4'((k + 1) % 15);
    k = r ? 0 : k + 1;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // monitor: every cycle after the edge, compare DUT outputs against the oldest queued expectation
  exp_t m;
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      m = q.pop_front();
      chk("led_out", {24'd0, led_out}, {24'd0, m.lo});
      chk("bright", dut.bright, m.br);
      chk("pwm_cnt", {28'd0, dut.pwm_cnt}, {28'd0, m.pc});
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) mb[i] = 0;
    step(1'b1, 8'hFF);
    step(1'b1, 8'hFF);
    repeat (5) step(1'b0, 8'hFF);
    step(1'b1, 8'h00);
    repeat (45) step(1'b0, 8'h01);
    step(1'b1, 8'h00);
    step(1'b0, 8'h01);
    repeat (34) step(1'b0, 8'h00);
    step(1'b0, 8'h01);
    repeat (70) step(1'b0, 8'h00);
    step(1'b0, 8'h01);
    repeat (10) step(1'b0, 8'h02);
    repeat (6) step(1'b0, 8'h04);
    step(1'b1, 8'hA5);
    repeat (3) step(1'b0, 8'h00);
    step(1'b0, 8'h01);
    step(1'b0, 8'h02);
    step(1'b0, 8'h04);
    repeat (4) step(1'b0, 8'h00);
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_pwm_trail.md
LED_PWM_TRAIL -- requirements
Module: led_pwm_trail

Interface
REQ-001 SHALL provide parameter DECAY_DIV, default 25000, meaning clk cycles per brightness decay step (legal range 1..65535).
REQ-002 SHALL provide port clk  input  1  rising-edge system clock, the only clock.
REQ-003 SHALL provide port rs  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port led_in  input  8  LED pattern from the upstream LED sequencer, one bit per LED, 1 = lit.
REQ-005 SHALL provide port led_out  output  8  registered PWM-dimmed drive to the physical LEDs.

Function
REQ-006 SHALL keep one 4-bit brightness register bright[i] per LED (0 = off, 15 = full).
REQ-007 SHALL run a 4-bit PWM counter pwm_cnt that counts 0..14 and wraps 14 -> 0, giving a 15-cycle frame.
REQ-008 SHALL register led_out[i] = (bright[i] > pwm_cnt) every cycle: bright 15 gives a constant 1, bright 0 gives a constant 0, bright k gives k high cycles per frame.
REQ-009 SHALL run a 16-bit prescaler counting 0..DECAY_DIV-1 and wrapping to 0; decay_tick is asserted in the cycle where prescaler == DECAY_DIV-1 (DECAY_DIV=1 asserts it every cycle).
REQ-010 SHALL load bright[i] = 15 at any edge where led_in[i] = 1, including when decay_tick coincides with it (load has priority over decay).
REQ-011 SHALL decrement bright[i] by 1 at an edge where led_in[i] = 0, decay_tick = 1 and bright[i] > 0.
REQ-012 SHALL hold bright[i] at 0: no wrap below zero.
REQ-013 SHALL otherwise hold bright[i] unchanged.
REQ-014 SHALL update all eight LEDs independently and in parallel, sharing one pwm_cnt and one decay_tick.
REQ-015 SHALL have a latency of 2 edges: led_in[i] rising sampled at edge N gives bright[i] = 15 after N and led_out[i] = 1 after N+1.
REQ-016 SHALL let pwm_cnt and the prescaler free-run regardless of led_in activity.
REQ-017 SHALL sample led_in without assuming any timing relation to the PWM frame or decay_tick.

Reset
REQ-018 SHALL, while rs = 1 at a rising edge, clear bright[0..7], pwm_cnt, the prescaler and led_out to 0.
REQ-019 SHALL give rs priority over led_in loads and decay.
REQ-020 SHALL, when rs is asserted mid-decay, drive led_out = 8'h00 after that edge and discard all trail state.
REQ-021 SHALL, on the first edge after rs falls, start pwm_cnt and the prescaler from 0.

Configuration
REQ-022 SHALL use the macro LED_PWM_TRAIL_EN to select trail decay.
REQ-023 With LED_PWM_TRAIL_EN defined, the block SHALL behave as REQ-009..REQ-013 (fading trail behind the running light).
REQ-024 With LED_PWM_TRAIL_EN undefined, the block SHALL set bright[i] = led_in[i] ? 15 : 0 every edge and omit the prescaler, so led_out equals led_in delayed 2 edges. Ports and reset behaviour are unchanged.

Verification (DECAY_DIV = 4 unless noted)
REQ-025 Reset: hold rs = 1 for 2 edges with led_in = 8'hFF -> led_out = 8'h00 and pwm_cnt = 0; release rs -> led_out = 8'hFF from the 2nd edge after release.
REQ-026 Full on: led_in = 8'h01 held for 45 cycles -> led_out[0] = 1 on every cycle after latency; led_out[7:1] = 0 throughout.
REQ-027 Trail (TRAIL_EN defined): led_in = 8'h01 then 8'h00 -> bright[0] steps 15 -> 14 -> ... -> 0, one step per 4 cycles; led_out[0] is high for k cycles per 15-cycle frame; led_out[0] = 0 permanently within 62 cycles.
REQ-028 Reload priority: led_in[0] re-asserted in the same cycle as decay_tick while bright[0] = 7 -> bright[0] = 15 after that edge, not 6.
REQ-029 Reset mid-operation: rs = 1 for 1 edge while bright = {15, 9, 3, 0, ...} -> led_out = 8'h00 and all bright = 0 after that edge.
REQ-030 No trail (TRAIL_EN undefined): walk led_in 8'h01 -> 8'h02 -> 8'h04, one pattern per cycle -> led_out shows the same sequence exactly 2 edges later with no residual glow.
